// File: rtl/spi_pkg.sv
// Shared types and widths for the SPI slave byte engine.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_slave_state_t;

  localparam int SPI_BYTE_W    = 8;
  localparam int SPI_BIT_CNT_W = 3;

endpackage

// File: rtl/spi_input_sync.sv
// Multi-bit flip-flop synchronizer chain with a per-bit reset value, used to
// bring the asynchronous SPI pins into the clk domain with identical latency.
module spi_input_sync
  import spi_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift the pin values through DEPTH stages; reset to the idle pin levels
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RESET_VAL;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/spi_slave_interface.sv
// SPI mode 3, LSB-first slave byte engine. SCL/CS/MOSI are oversampled in the
// clk domain; received bytes are strobed out and transmit bytes come from a
// single-entry holding register.
module spi_slave_interface
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  scl,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [SPI_BYTE_W-1:0] tx_byte,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [SPI_BYTE_W-1:0] rx_byte,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  frame_error,
  output logic                  tx_underrun
);

  logic [2:0] syncOut;
  logic       sclSync, csSync, mosiSync;

  logic sclPrev_q, csPrev_q;
  logic sclRise_q, sclFall_q, csRise_q, csFall_q;
  logic mosiDly_q;

  spi_slave_state_t state_q, state_d;

  logic [SPI_BIT_CNT_W-1:0] bitCnt_q, bitCnt_d;
  logic [SPI_BYTE_W-1:0]    rxShift_q, rxShift_d;
  logic [SPI_BYTE_W-1:0]    txShift_q, txShift_d;
  logic [SPI_BYTE_W-1:0]    rxByte_q, rxByte_d;
  logic [SPI_BYTE_W-1:0]    hold_q, hold_d;
  logic                     holdFull_q, holdFull_d;
  logic                     miso_q, miso_d;
  logic                     rxValid_q, rxValid_d;
  logic                     frameErr_q, frameErr_d;
  logic                     underrun_q, underrun_d;
  logic                     reload;

  spi_input_sync #(
    .WIDTH    (3),
    .DEPTH    (SYNC_STAGES),
    .RESET_VAL(3'b110)
  ) uSync (
    .clk  (clk),
    .arstn(arstn),
    .d_i  ({scl, cs, mosi}),
    .q_o  (syncOut)
  );

  assign sclSync  = syncOut[2];
  assign csSync   = syncOut[1];
  assign mosiSync = syncOut[0];

  // Register edge pulses and the matching MOSI sample so all three pins share latency
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      sclPrev_q <= 1'b1;
      csPrev_q  <= 1'b1;
      sclRise_q <= 1'b0;
      sclFall_q <= 1'b0;
      csRise_q  <= 1'b0;
      csFall_q  <= 1'b0;
      mosiDly_q <= 1'b0;
    end else begin
      sclPrev_q <= sclSync;
      csPrev_q  <= csSync;
      sclRise_q <= sclSync & ~sclPrev_q;
      sclFall_q <= ~sclSync & sclPrev_q;
      csRise_q  <= csSync & ~csPrev_q;
      csFall_q  <= ~csSync & csPrev_q;
      mosiDly_q <= mosiSync;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: chip select alone opens and closes a frame
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (csFall_q) state_d = ACTIVE;
      ACTIVE:  if (csRise_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: busy and the pad enable both track the active frame
  always_comb begin
    busy    = (state_q != IDLE);
    miso_oe = (state_q == ACTIVE);
  end

  // Datapath next state: shifting, byte completion, TX reload and holding register
  always_comb begin
    bitCnt_d   = bitCnt_q;
    rxShift_d  = rxShift_q;
    txShift_d  = txShift_q;
    rxByte_d   = rxByte_q;
    hold_d     = hold_q;
    holdFull_d = holdFull_q;
    miso_d     = miso_q;
    rxValid_d  = 1'b0;
    frameErr_d = 1'b0;
    underrun_d = 1'b0;
    reload     = 1'b0;

    if (state_q == IDLE) begin
      if (csFall_q) begin
        bitCnt_d = '0;
        reload   = 1'b1;
      end
    end else if (csRise_q) begin
      frameErr_d = (bitCnt_q != '0);
      bitCnt_d   = '0;
      rxShift_d  = '0;
      txShift_d  = '0;
      miso_d     = 1'b0;
    end else begin
      if (sclRise_q) begin
        rxShift_d = {mosiDly_q, rxShift_q[SPI_BYTE_W-1:1]};
        bitCnt_d  = bitCnt_q + SPI_BIT_CNT_W'(1);
        if (bitCnt_q == '1) begin
          rxByte_d  = rxShift_d;
          rxValid_d = 1'b1;
          reload    = 1'b1;
        end
      end
      if (sclFall_q) begin
        miso_d    = txShift_q[0];
        txShift_d = {1'b0, txShift_q[SPI_BYTE_W-1:1]};
      end
    end

    if (reload) begin
      if (holdFull_q) begin
        txShift_d  = hold_q;
        holdFull_d = 1'b0;
      end else begin
        txShift_d  = '0;
        underrun_d = 1'b1;
      end
    end

    if (tx_load && !holdFull_q) begin
      hold_d     = tx_byte;
      holdFull_d = 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      bitCnt_q   <= '0;
      rxShift_q  <= '0;
      txShift_q  <= '0;
      rxByte_q   <= '0;
      hold_q     <= '0;
      holdFull_q <= 1'b0;
      miso_q     <= 1'b0;
      rxValid_q  <= 1'b0;
      frameErr_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      bitCnt_q   <= bitCnt_d;
      rxShift_q  <= rxShift_d;
      txShift_q  <= txShift_d;
      rxByte_q   <= rxByte_d;
      hold_q     <= hold_d;
      holdFull_q <= holdFull_d;
      miso_q     <= miso_d;
      rxValid_q  <= rxValid_d;
      frameErr_q <= frameErr_d;
      underrun_q <= underrun_d;
    end
  end

  assign miso        = miso_q;
  assign tx_ready    = ~holdFull_q;
  assign rx_byte     = rxByte_q;
  assign rx_valid    = rxValid_q;
  assign frame_error = frameErr_q;
  assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_interface.sv
// Scoreboard bench for spi_slave_interface: a behavioural SPI master drives
// frames, a queue-based model predicts received bytes and returned bytes, and
// a monitor compares DUT strobes against the queues.
module tb_spi_slave_interface;

  logic       clk = 1'b0;
  logic       arstn, scl, cs, mosi, miso, miso_oe;
  logic [7:0] tx_byte, rx_byte;
  logic       tx_load, tx_ready, rx_valid, busy, frame_error, tx_underrun;

  int total = 0;
  int bad   = 0;

  logic [7:0] expRxQ[$];
  logic [7:0] expMisoQ[$];
  logic [7:0] obsMisoQ[$];
  logic [7:0] holdQ[$];
  logic [7:0] lastRx = 8'h00;
  logic [7:0] frameData [4];
  logic [7:0] monExp, monObs;
  int expUnderrun = 0, gotUnderrun = 0;
  int expFrameErr = 0, gotFrameErr = 0;

  spi_slave_interface #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .arstn      (arstn),
    .scl        (scl),
    .cs         (cs),
    .mosi       (mosi),
    .miso       (miso),
    .miso_oe    (miso_oe),
    .tx_byte    (tx_byte),
    .tx_load    (tx_load),
    .tx_ready   (tx_ready),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .busy       (busy),
    .frame_error(frame_error),
    .tx_underrun(tx_underrun)
  );

  // 100 MHz system clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model of the holding register: at most one byte, extra loads dropped
  task automatic modelReload(output logic [7:0] m);
    if (holdQ.size() > 0) begin
      m = holdQ.pop_front();
    end else begin
      m = 8'h00;
      expUnderrun++;
    end
  endtask

  task automatic doLoad(input logic [7:0] v);
    tx_byte = v;
    tx_load = 1'b1;
    if (holdQ.size() == 0) holdQ.push_back(v);
    waitClk(1);
    tx_load = 1'b0;
  endtask

  // Behavioural mode-3 LSB-first master; stopRises>0 abandons the frame with CS still low
  task automatic applyStimulus(input int nBytes, input int stopRises, input int half);
    logic [7:0] m, got;
    int rises;
    rises = 0;
    cs = 1'b0;
    modelReload(m);
    waitClk(6);
    for (int b = 0; b < nBytes; b++) begin
      got = 8'h00;
      for (int i = 0; i < 8; i++) begin
        scl  = 1'b0;
        mosi = frameData[b][i];
        waitClk(half);
        got[i] = miso;
        scl = 1'b1;
        rises++;
        if (i == 7) begin
          expRxQ.push_back(frameData[b]);
          lastRx = frameData[b];
          expMisoQ.push_back(m);
          obsMisoQ.push_back(got);
          modelReload(m);
        end
        waitClk(half);
        if (stopRises != 0 && rises == stopRises) return;
      end
    end
    cs = 1'b1;
    waitClk(8);
  endtask

  task automatic endCheck(input string tag);
    waitClk(12);
    checkOutput({tag, "_rx_pending"}, expRxQ.size(), 0);
    checkOutput({tag, "_miso_pending"}, expMisoQ.size(), 0);
    checkOutput({tag, "_underrun_cnt"}, gotUnderrun, expUnderrun);
    checkOutput({tag, "_frame_err_cnt"}, gotFrameErr, expFrameErr);
    checkOutput({tag, "_rx_byte_hold"}, rx_byte, lastRx);
    checkOutput({tag, "_tx_ready"}, tx_ready, (holdQ.size() == 0));
    checkOutput({tag, "_busy_idle"}, busy, 0);
    checkOutput({tag, "_miso_oe_idle"}, miso_oe, 0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_miso"}, miso, 0);
    checkOutput({tag, "_miso_oe"}, miso_oe, 0);
    checkOutput({tag, "_rx_byte"}, rx_byte, 8'h00);
    checkOutput({tag, "_rx_valid"}, rx_valid, 0);
    checkOutput({tag, "_tx_ready"}, tx_ready, 1);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_frame_error"}, frame_error, 0);
    checkOutput({tag, "_tx_underrun"}, tx_underrun, 0);
  endtask

  // Monitor: pop expected results whenever the DUT strobes or the master returns a byte
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      if (expRxQ.size() == 0) begin
        checkOutput("rx_valid_unexpected", 1, 0);
      end else begin
        monExp = expRxQ.pop_front();
        checkOutput("rx_byte", rx_byte, monExp);
      end
    end
    if (tx_underrun === 1'b1) gotUnderrun++;
    if (frame_error === 1'b1) gotFrameErr++;
    while (obsMisoQ.size() > 0) begin
      monObs = obsMisoQ.pop_front();
      if (expMisoQ.size() == 0) begin
        checkOutput("miso_unexpected", 1, 0);
      end else begin
        monExp = expMisoQ.pop_front();
        checkOutput("miso_byte", monObs, monExp);
      end
    end
  end

  // Hard time limit so the bench can never hang
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    arstn   = 1'b0;
    scl     = 1'b1;
    cs      = 1'b1;
    mosi    = 1'b0;
    tx_load = 1'b0;
    tx_byte = 8'h00;
    #12;
    checkResetOutputs("por");
    waitClk(2);
    arstn = 1'b1;
    waitClk(5);

    $display("[TB] preload A5, receive 3C");
    doLoad(8'hA5);
    checkOutput("t1_tx_ready_after_load", tx_ready, 0);
    frameData[0] = 8'h3C;
    applyStimulus(1, 0, 8);
    endCheck("t1");

    $display("[TB] no preload, receive 81");
    frameData[0] = 8'h81;
    applyStimulus(1, 0, 7);
    endCheck("t2");

    $display("[TB] three bytes with loads on tx_ready");
    doLoad(8'h10);
    frameData[0] = 8'h01;
    frameData[1] = 8'h02;
    frameData[2] = 8'h03;
    fork
      applyStimulus(3, 0, 8);
      begin
        logic [7:0] nextVal;
        for (int k = 0; k < 2; k++) begin
          nextVal = (k == 0) ? 8'h20 : 8'h30;
          for (int c = 0; c < 400 && tx_ready !== 1'b1; c++) waitClk(1);
          if (tx_ready !== 1'b1) checkOutput("t3_load_timeout", tx_ready, 1);
          else doLoad(nextVal);
        end
      end
    join
    endCheck("t3");

    $display("[TB] CS rise after five bits");
    frameData[0] = 8'($urandom);
    applyStimulus(1, 5, 8);
    cs = 1'b1;
    expFrameErr++;
    waitClk(8);
    endCheck("t4_abort");
    frameData[0] = 8'h55;
    applyStimulus(1, 0, 6);
    endCheck("t4_next");

    $display("[TB] second load while full is dropped");
    doLoad(8'h11);
    waitClk(2);
    doLoad(8'h22);
    frameData[0] = 8'($urandom);
    applyStimulus(1, 0, 8);
    endCheck("t5");

    $display("[TB] reset in the middle of a byte");
    doLoad(8'($urandom));
    frameData[0] = 8'($urandom);
    applyStimulus(1, 4, 8);
    arstn = 1'b0;
    #1;
    checkResetOutputs("midrst");
    holdQ.delete();
    lastRx = 8'h00;
    scl  = 1'b1;
    cs   = 1'b1;
    mosi = 1'b0;
    waitClk(3);
    arstn = 1'b1;
    waitClk(10);
    endCheck("t6_release");
    frameData[0] = 8'hC3;
    applyStimulus(1, 0, 8);
    endCheck("t6_next");

    $display("[TB] randomized frames");
    for (int r = 0; r < 6; r++) begin
      int nb, hp;
      nb = int'($urandom_range(3, 1));
      hp = int'($urandom_range(9, 5));
      if ($urandom_range(1, 0) == 1) doLoad(8'($urandom));
      for (int b = 0; b < nb; b++) frameData[b] = 8'($urandom);
      applyStimulus(nb, 0, hp);
      endCheck("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
